// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the icache/dcache memory-port arbiter.
// The FSM states, grant identities and line-address width helper live here.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RDATA,
    ST_WDATA,
    ST_WACK
  } state_e;

  typedef enum logic {
    GRANT_IC = 1'b0,
    GRANT_DC = 1'b1
  } grant_e;

  localparam int DEF_LINE_WORDS = 8;

  // Line address drops the byte offset (2 bits) and the word-in-line offset.
  function automatic int line_aw(input int words);
    return 30 - $clog2(words);
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way pick between icache and dcache, round-robin or icache-first on a tie.
// Holds last_grant, which also identifies the grantee for the rest of a transaction.
module arb_rr2
  import mem_arbiter_pkg::*;
#(
  parameter bit IC_PRIO = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_ic,
  input  logic req_dc,
  input  logic update,
  output logic pick_dc,
  output logic last_dc
);

  grant_e last_grant_q, last_grant_d;

  // On a tie the round-robin choice is the requester that did not win last time.
  always_comb begin
    if (req_ic && req_dc) pick_dc = IC_PRIO ? 1'b0 : (last_grant_q == GRANT_IC);
    else                  pick_dc = req_dc;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (update) last_grant_d = pick_dc ? GRANT_DC : GRANT_IC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= GRANT_DC;
    else        last_grant_q <= last_grant_d;
  end

  assign last_dc = (last_grant_q == GRANT_DC);

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single external memory port between icache line refills and dcache reads/writebacks.
// One transaction at a time; the FSM sequences the address, write-data and read-data beats.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int  LINE_WORDS = DEF_LINE_WORDS,
  parameter bit  IC_PRIO    = 1'b0,
  localparam int AW         = line_aw(LINE_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          icache_arb_req,
  input  logic [AW-1:0] icache_arb_addr,
  input  logic          icache_arb_abort,
  output logic          arb_icache_ready,
  output logic          arb_icache_valid,
  output logic          arb_icache_error,
  output logic [31:0]   arb_icache_data,
  input  logic          dcache_arb_req,
  input  logic          dcache_arb_we,
  input  logic [AW-1:0] dcache_arb_addr,
  input  logic [31:0]   dcache_arb_wdata,
  output logic          arb_dcache_wready,
  output logic          arb_dcache_ready,
  output logic          arb_dcache_valid,
  output logic          arb_dcache_error,
  output logic [31:0]   arb_dcache_data,
  output logic          arb_mem_req,
  output logic          arb_mem_we,
  output logic [AW-1:0] arb_mem_addr,
  input  logic          mem_ready,
  output logic          arb_mem_wvalid,
  output logic [31:0]   arb_mem_wdata,
  input  logic          mem_wready,
  input  logic          mem_valid,
  input  logic          mem_error,
  input  logic [31:0]   mem_data
);

  localparam int CW = $clog2(LINE_WORDS);

  state_e        state_q, state_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          abort_q, abort_d;
  logic          req_ic, any_req, grant_upd, pick_dc, last_dc;
  logic          is_ic, is_dc, last_beat, ic_drop;

  assign req_ic    = icache_arb_req & ~icache_arb_abort;
  assign any_req   = req_ic | dcache_arb_req;
  assign grant_upd = (state_q == ST_IDLE) & any_req;
  assign is_dc     = last_dc;
  assign is_ic     = ~last_dc;
  assign last_beat = (beat_cnt_q == CW'(LINE_WORDS - 1));
  // Once the icache has aborted, its remaining beats are drained silently.
  assign ic_drop   = is_ic & (abort_q | icache_arb_abort);

  arb_rr2 #(.IC_PRIO(IC_PRIO)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_ic  (req_ic),
    .req_dc  (dcache_arb_req),
    .update  (grant_upd),
    .pick_dc (pick_dc),
    .last_dc (last_dc)
  );

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    abort_d    = abort_q;
    case (state_q)
      ST_IDLE: begin
        beat_cnt_d = '0;
        abort_d    = 1'b0;
        if (any_req) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (mem_ready) begin
          state_d = (is_dc && dcache_arb_we) ? ST_WDATA : ST_RDATA;
          abort_d = is_ic && icache_arb_abort;
        end else if (is_ic && icache_arb_abort) begin
          state_d = ST_IDLE;
        end
      end
      ST_RDATA: begin
        if (is_ic && icache_arb_abort) abort_d = 1'b1;
        if (mem_valid) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (last_beat) begin
            state_d = ST_IDLE;
            abort_d = 1'b0;
          end
        end
      end
      ST_WDATA: begin
        if (mem_wready) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (last_beat) state_d = ST_WACK;
        end
      end
      ST_WACK: begin
        if (mem_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      abort_q    <= abort_d;
    end
  end

  // Every output is decoded from the state, so IDLE (and reset) drives them all low.
  always_comb begin
    arb_icache_ready  = 1'b0;
    arb_icache_valid  = 1'b0;
    arb_icache_error  = 1'b0;
    arb_icache_data   = '0;
    arb_dcache_wready = 1'b0;
    arb_dcache_ready  = 1'b0;
    arb_dcache_valid  = 1'b0;
    arb_dcache_error  = 1'b0;
    arb_dcache_data   = '0;
    arb_mem_req       = 1'b0;
    arb_mem_we        = 1'b0;
    arb_mem_addr      = '0;
    arb_mem_wvalid    = 1'b0;
    arb_mem_wdata     = '0;
    case (state_q)
      ST_ADDR: begin
        arb_mem_req      = 1'b1;
        arb_mem_we       = is_dc & dcache_arb_we;
        arb_mem_addr     = is_dc ? dcache_arb_addr : icache_arb_addr;
        arb_icache_ready = is_ic & mem_ready;
        arb_dcache_ready = is_dc & mem_ready;
      end
      ST_RDATA: begin
        if (is_dc) begin
          arb_dcache_valid = mem_valid;
          arb_dcache_error = mem_valid & mem_error;
          arb_dcache_data  = mem_data;
        end else begin
          arb_icache_valid = mem_valid & ~ic_drop;
          arb_icache_error = mem_valid & mem_error & ~ic_drop;
          arb_icache_data  = mem_data;
        end
      end
      ST_WDATA: begin
        arb_mem_wvalid    = 1'b1;
        arb_mem_wdata     = dcache_arb_wdata;
        arb_dcache_wready = mem_wready;
      end
      ST_WACK: begin
        arb_dcache_valid = mem_valid;
        arb_dcache_error = mem_valid & mem_error;
      end
      default: ;
    endcase
  end

endmodule
